// File: rtl/spi_adc_responder.sv
// SPI responder emulating an 8-channel 12-bit MCP3208-style ADC.
// Each frame returns the sample of the channel addressed by the previous complete frame.
module spi_adc_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [95:0] ch_data,
  output logic        frame_done,
  output logic        frame_err,
  output logic [2:0]  last_addr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_END    = 2'd2;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_q;
  logic                   cs_q;

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic sck_rise;
  logic sck_fall;
  logic cs_fall;
  logic cs_rise;

  logic [1:0]  state;
  logic [15:0] resp;
  logic [4:0]  rise_cnt;
  logic [2:0]  addr_sr;
  logic [2:0]  pend_addr;
  logic [11:0] ch_arr [8];
  logic [15:0] resp_snap;

  // Synchronizers reset to the idle bus levels so no edge is seen on reset release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_q     <= sck_sync[SYNC_STAGES-1];
      cs_q      <= cs_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sck_s    = sck_sync[SYNC_STAGES-1];
    cs_s     = cs_sync[SYNC_STAGES-1];
    mosi_s   = mosi_sync[SYNC_STAGES-1];
    sck_rise = sck_s & ~sck_q & ~cs_s;
    sck_fall = ~sck_s & sck_q & ~cs_s;
    cs_fall  = ~cs_s & cs_q;
    cs_rise  = cs_s & ~cs_q;
  end

  always_comb begin
    for (int unsigned n = 0; n < 8; n++) begin
      ch_arr[n] = ch_data[12*n +: 12];
    end
    resp_snap = {4'b0000, ch_arr[pend_addr]};
  end

  always_comb begin
    spi_miso_oe = (state == ST_ACTIVE);
  end

  // Only rises 3..5 carry the channel address, so only those bits are retained.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      resp       <= '0;
      rise_cnt   <= '0;
      addr_sr    <= '0;
      pend_addr  <= '0;
      last_addr  <= '0;
      spi_miso   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          spi_miso <= 1'b0;
          if (cs_fall) begin
            resp     <= resp_snap;
            rise_cnt <= '0;
            spi_miso <= resp_snap[15];
            state    <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state <= ST_END;
          end else begin
            if (sck_rise) begin
              if (rise_cnt >= 5'd2 && rise_cnt <= 5'd4) begin
                addr_sr <= {addr_sr[1:0], mosi_s};
              end
              if (rise_cnt != 5'd31) begin
                rise_cnt <= rise_cnt + 5'd1;
              end
            end
            if (sck_fall) begin
              if (!rise_cnt[4]) begin
                spi_miso <= resp[4'd15 - rise_cnt[3:0]];
              end else begin
                spi_miso <= 1'b0;
              end
            end
          end
        end
        ST_END: begin
          spi_miso <= 1'b0;
          if (rise_cnt >= 5'd16) begin
            pend_addr  <= addr_sr;
            last_addr  <= addr_sr;
            frame_done <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: begin
          spi_miso <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: an SPI master task drives frames and checks
// the pipelined sample, frame pulses and last_addr against hand-computed values.
module tb_spi_adc_responder;

  localparam int HALF = 8;

  logic        clk;
  logic        rst;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [95:0] ch_data;
  logic        frame_done;
  logic        frame_err;
  logic [2:0]  last_addr;

  int errors = 0;
  int checks = 0;

  spi_adc_responder #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (spi_sck),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .ch_data    (ch_data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .last_addr  (last_addr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One master frame. rst_at > 0 pulls rst low right after that rise and abandons the frame.
  task automatic spi_frame(input logic [2:0] addr, input int nrise,
                           input int chg_at, input logic [95:0] chg_val,
                           input int rst_at,
                           output logic [15:0] word, output int n_done, output int n_err);
    logic [15:0] cmd;
    cmd    = {2'b11, addr, 11'd0};
    word   = '0;
    n_done = 0;
    n_err  = 0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    check("oe_in_frame", {31'd0, spi_miso_oe}, 32'd1);
    for (int i = 0; i < nrise; i++) begin
      spi_mosi = (i < 16) ? cmd[15-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (i < 16) word[15-i] = spi_miso;
      spi_sck = 1'b1;
      if (i + 1 == chg_at) ch_data = chg_val;
      if (i + 1 == rst_at) begin
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("oe_after_rst", {31'd0, spi_miso_oe}, 32'd0);
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        repeat (12) begin
          @(negedge clk);
          if (frame_done) n_done++;
          if (frame_err)  n_err++;
        end
        rst = 1'b1;
        repeat (12) begin
          @(negedge clk);
          if (frame_done) n_done++;
          if (frame_err)  n_err++;
        end
        return;
      end
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (frame_done) n_done++;
      if (frame_err)  n_err++;
    end
    repeat (4) @(negedge clk);
  endtask

  logic [15:0] word;
  int          nd;
  int          ne;
  logic [2:0]  prev;
  logic [15:0] exp_w;
  logic [95:0] tmp;

  initial begin
    rst      = 1'b0;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    ch_data  = '0;
    repeat (4) @(negedge clk);
    check("rst_miso",  {31'd0, spi_miso},    32'd0);
    check("rst_oe",    {31'd0, spi_miso_oe}, 32'd0);
    check("rst_done",  {31'd0, frame_done},  32'd0);
    check("rst_err",   {31'd0, frame_err},   32'd0);
    check("rst_laddr", {29'd0, last_addr},   32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Frame addressing channel 1; reset left channel 0 pending.
    ch_data[11:0] = 12'hABC;
    spi_frame(3'd1, 16, 0, '0, 0, word, nd, ne);
    check("f1_word",  {16'd0, word}, 32'h0ABC);
    check("f1_done",  nd, 1);
    check("f1_err",   ne, 0);
    check("f1_laddr", {29'd0, last_addr}, 32'd1);

    // Channel 1 now returns as the pipelined sample.
    ch_data[23:12] = 12'h5A5;
    spi_frame(3'd0, 16, 0, '0, 0, word, nd, ne);
    check("f2_word",  {16'd0, word}, 32'h05A5);
    check("f2_bits",  {24'd0, word[11:4]}, 32'h5A);
    check("f2_done",  nd, 1);
    check("f2_laddr", {29'd0, last_addr}, 32'd0);

    // Address sweep; channel n holds 0x100*n + 0x11.
    for (int n = 0; n < 8; n++) ch_data[12*n +: 12] = 12'h100 * n[11:0] + 12'h011;
    prev = 3'd0;
    for (int a = 0; a < 8; a++) begin
      spi_frame(a[2:0], 16, 0, '0, 0, word, nd, ne);
      exp_w = 16'h0100 * {13'd0, prev} + 16'h0011;
      check("sweep_word",  {16'd0, word}, {16'd0, exp_w});
      check("sweep_done",  nd, 1);
      check("sweep_laddr", {29'd0, last_addr}, a);
      prev = a[2:0];
    end

    // Aborted frame addressing channel 5 after 8 rises.
    spi_frame(3'd5, 8, 0, '0, 0, word, nd, ne);
    check("abort_err",   ne, 1);
    check("abort_done",  nd, 0);
    check("abort_laddr", {29'd0, last_addr}, 32'd7);
    spi_frame(3'd2, 16, 0, '0, 0, word, nd, ne);
    check("post_abort_word",  {16'd0, word}, 32'h0711);
    check("post_abort_laddr", {29'd0, last_addr}, 32'd2);

    // ch_data change mid-frame: current frame keeps the CS-fall snapshot.
    tmp = ch_data;
    tmp[35:24] = 12'hDEF;
    spi_frame(3'd2, 16, 4, tmp, 0, word, nd, ne);
    check("midchg_word", {16'd0, word}, 32'h0211);
    spi_frame(3'd3, 16, 0, '0, 0, word, nd, ne);
    check("midchg_next", {16'd0, word}, 32'h0DEF);
    check("midchg_laddr", {29'd0, last_addr}, 32'd3);

    // Reset mid-frame at rise 10; channel 3 was pending before it.
    spi_frame(3'd6, 16, 0, '0, 10, word, nd, ne);
    check("rst_frame_done", nd, 0);
    check("rst_frame_err",  ne, 0);
    check("rst_frame_laddr", {29'd0, last_addr}, 32'd0);
    spi_frame(3'd1, 16, 0, '0, 0, word, nd, ne);
    check("after_rst_word",  {16'd0, word}, 32'h0011);
    check("after_rst_laddr", {29'd0, last_addr}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
